// File: rtl/i2s_seq_pkg.sv
// rtl/i2s_seq_pkg.sv - shared command codes, FSM states and status bit positions for the capture sequencer
package i2s_seq_pkg;

    typedef enum logic [7:0] {
        CMD_START  = 8'h01,
        CMD_STOP   = 8'h02,
        CMD_STATUS = 8'h03,
        CMD_READ   = 8'h04,
        CMD_FLUSH  = 8'h05
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ARG_LEN,
        ST_STAT_HI,
        ST_STAT_LO,
        ST_RD_POP,
        ST_RD_LATCH,
        ST_RD_SEND
    } seq_state_e;

    localparam int STAT_CAPTURE = 7;
    localparam int STAT_OVF     = 6;
    localparam int STAT_TIMEOUT = 5;
    localparam int STAT_FULL    = 4;
    localparam int STAT_EMPTY   = 3;

    localparam logic [7:0] PAD_BYTE = 8'h00;
    localparam logic [7:0] BAD_CMD  = 8'hEE;

endpackage

// File: rtl/i2s_seq_timeout.sv
// rtl/i2s_seq_timeout.sv - idle cycle counter with synchronous clear and a one-cycle expire pulse
module i2s_seq_timeout #(
    parameter int CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expire_q, expire_d;

    always_comb begin
        cnt_d    = '0;
        expire_d = 1'b0;
        if (!clr && en) begin
            if (cnt_q == W'(CYCLES - 1)) begin
                expire_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/i2s_capture_sequencer.sv
// rtl/i2s_capture_sequencer.sv - SPI command sequencer gating I2S capture and draining the sample FIFO
// Optional idle auto-stop is built when CAPTURE_TIMEOUT_EN is defined.
module i2s_capture_sequencer
    import i2s_seq_pkg::*;
#(
    parameter int COUNT_W        = 17,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_cs_n,
    input  logic               spi_rx_valid,
    input  logic [7:0]         spi_rx_data,
    output logic [7:0]         spi_tx_data,
    output logic               fifo_rd_en,
    input  logic [7:0]         fifo_rd_data,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [COUNT_W-1:0] fifo_count,
    output logic               capture_en,
    output logic               fifo_flush
);

    seq_state_e  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        frame_used_q, frame_used_d;
    logic [7:0]  tx_q, tx_d;
    logic        cap_q, cap_d;
    logic        ovf_q, ovf_d;
    logic        tmo_q, tmo_d;
    logic [8:0]  rem_q, rem_d;
    logic        popped_q, popped_d;
    logic [15:0] snap_q, snap_d;

    logic        rx_byte, cmd_slot, start_hit, flush_hit, expire;
    logic [31:0] cnt_wide;
    logic [15:0] cnt_sat;
    logic [7:0]  status_byte;

    assign rx_byte   = spi_rx_valid && !spi_cs_n;
    // Only the first byte of a CS frame is a command; later strays are ignored.
    assign cmd_slot  = rx_byte && (state_q == ST_IDLE) && !frame_used_q;
    assign start_hit = cmd_slot && (spi_rx_data == CMD_START);
    assign flush_hit = (state_q == ST_CMD) && (cmd_q == CMD_FLUSH);
    assign cnt_wide  = 32'(fifo_count);
    assign cnt_sat   = (cnt_wide > 32'h0000_FFFF) ? 16'hFFFF : cnt_wide[15:0];

`ifdef CAPTURE_TIMEOUT_EN
    i2s_seq_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (spi_rx_valid || start_hit),
        .en     (cap_q),
        .expire (expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire             = 1'b0;
`endif

    always_comb begin
        status_byte               = 8'h00;
        status_byte[STAT_CAPTURE] = cap_q;
        status_byte[STAT_OVF]     = ovf_q;
        status_byte[STAT_TIMEOUT] = tmo_q;
        status_byte[STAT_FULL]    = fifo_full;
        status_byte[STAT_EMPTY]   = fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (spi_cs_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (cmd_slot) state_d = ST_CMD;
                ST_CMD: begin
                    case (cmd_q)
                        CMD_STATUS: state_d = ST_STAT_HI;
                        CMD_READ:   state_d = ST_ARG_LEN;
                        default:    state_d = ST_IDLE;
                    endcase
                end
                ST_STAT_HI:  if (rx_byte) state_d = ST_STAT_LO;
                ST_STAT_LO:  if (rx_byte) state_d = ST_IDLE;
                ST_ARG_LEN:  if (rx_byte) state_d = ST_RD_POP;
                ST_RD_POP:   state_d = ST_RD_LATCH;
                ST_RD_LATCH: state_d = ST_RD_SEND;
                ST_RD_SEND:  if (rx_byte) state_d = (rem_q != 9'd0) ? ST_RD_POP : ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_rd_en = (state_q == ST_RD_POP) && !fifo_empty && !spi_cs_n;
        fifo_flush = flush_hit;
    end

    always_comb begin
        cmd_d        = cmd_q;
        frame_used_d = frame_used_q;
        tx_d         = tx_q;
        cap_d        = cap_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        rem_d        = rem_q;
        popped_d     = popped_q;
        snap_d       = snap_q;

        if (cap_q && fifo_full) ovf_d = 1'b1;
        if (flush_hit)          ovf_d = 1'b0;
        if (expire) begin
            cap_d = 1'b0;
            tmo_d = 1'b1;
        end

        if (spi_cs_n) begin
            frame_used_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_slot) begin
                        frame_used_d = 1'b1;
                        cmd_d        = spi_rx_data;
                        case (spi_rx_data)
                            CMD_START: begin
                                cap_d = 1'b1;
                                ovf_d = 1'b0;
                                tmo_d = 1'b0;
                            end
                            CMD_STOP:   cap_d = 1'b0;
                            CMD_STATUS: begin
                                tx_d   = status_byte;
                                snap_d = cnt_sat;
                            end
                            CMD_READ, CMD_FLUSH: ;
                            default:    tx_d = BAD_CMD;
                        endcase
                    end
                end
                ST_STAT_HI:  if (rx_byte) tx_d = snap_q[15:8];
                ST_STAT_LO:  if (rx_byte) tx_d = snap_q[7:0];
                ST_ARG_LEN:  if (rx_byte) rem_d = (spi_rx_data == 8'd0) ? 9'd256 : {1'b0, spi_rx_data};
                ST_RD_POP:   popped_d = !fifo_empty;
                ST_RD_LATCH: begin
                    // Empty FIFO at pop time still consumes one byte of the burst.
                    tx_d = popped_q ? fifo_rd_data : PAD_BYTE;
                    if (rem_q != 9'd0) rem_d = rem_q - 9'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= 8'h00;
            frame_used_q <= 1'b0;
            tx_q         <= 8'h00;
            cap_q        <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
            rem_q        <= 9'd0;
            popped_q     <= 1'b0;
            snap_q       <= 16'h0000;
        end else begin
            cmd_q        <= cmd_d;
            frame_used_q <= frame_used_d;
            tx_q         <= tx_d;
            cap_q        <= cap_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            rem_q        <= rem_d;
            popped_q     <= popped_d;
            snap_q       <= snap_d;
        end
    end

    assign spi_tx_data = tx_q;
    assign capture_en  = cap_q;

endmodule

// File: tb/tb_i2s_capture_sequencer.sv
// tb/tb_i2s_capture_sequencer.sv - scoreboard bench for the capture sequencer with a small FIFO model
module tb_i2s_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_n;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_data;
    logic [7:0]  spi_tx_data;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [16:0] fifo_count;
    logic        capture_en;
    logic        fifo_flush;

    logic [7:0]  fmem [0:15];
    int          wr_ptr;
    int          rd_ptr;
    int          pop_cnt;
    int          flush_cnt;
    logic        force_full;
    logic [7:0]  sb [$];
    int          n_checks;
    int          n_err;

    always #5 clk = ~clk;

    i2s_capture_sequencer #(
        .COUNT_W        (17),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_data  (spi_tx_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .capture_en   (capture_en),
        .fifo_flush   (fifo_flush)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_full  = force_full;

    initial begin
        rd_ptr       = 0;
        pop_cnt      = 0;
        flush_cnt    = 0;
        fifo_rd_data = 8'h00;
    end

    always @(posedge clk) begin
        if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
        if (fifo_flush) flush_cnt <= flush_cnt + 1;
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_rd_data <= fmem[rd_ptr % 16];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic fifo_fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr % 16] = base + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // The byte shifted out during this transfer is what tx held just before rx_valid.
    task automatic xfer(input logic [7:0] d);
        logic [7:0] exp;
        @(negedge clk);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check($sformatf("tx_byte_%0d", n_checks), {24'h0, spi_tx_data}, {24'h0, exp});
        end
        spi_rx_valid = 1'b1;
        spi_rx_data  = d;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        spi_rx_data  = 8'h00;
        repeat (6) @(negedge clk);
    endtask

    task automatic one_cmd(input logic [7:0] c);
        frame_begin();
        xfer(c);
        frame_end();
    endtask

    task automatic do_status(input logic [7:0] st, input logic [15:0] cnt);
        frame_begin();
        xfer(8'h03);
        sb.push_back(st);
        sb.push_back(cnt[15:8]);
        sb.push_back(cnt[7:0]);
        repeat (3) xfer(8'h5A);
        frame_end();
    endtask

    task automatic do_read(input logic [7:0] len, input int n_dummy);
        frame_begin();
        xfer(8'h04);
        xfer(len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int p0;
        int f0;
        n_checks     = 0;
        n_err        = 0;
        wr_ptr       = 0;
        force_full   = 1'b0;
        fifo_count   = 17'd0;
        rst_n        = 1'b0;
        spi_cs_n     = 1'b1;
        spi_rx_valid = 1'b0;
        spi_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", {24'h0, spi_tx_data}, 32'h00);
        check("rst_cap", {31'h0, capture_en}, 32'h0);
        check("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        check("rst_flush", {31'h0, fifo_flush}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        one_cmd(8'h01);
        check("start_cap", {31'h0, capture_en}, 32'h1);
        one_cmd(8'h02);
        check("stop_cap", {31'h0, capture_en}, 32'h0);

        one_cmd(8'h01);
        fifo_count = 17'd300;
        do_status(8'h88, 16'd300);
        fifo_count = 17'd70000;
        do_status(8'h88, 16'hFFFF);
        fifo_count = 17'd5;

        fifo_fill(8'hA0, 4);
        p0 = pop_cnt;
        do_read(8'd4, 0);
        sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3);
        repeat (4) xfer(8'h00);
        frame_end();
        check("read4_pops", pop_cnt - p0, 32'd4);

        fifo_fill(8'hA0, 2);
        p0 = pop_cnt;
        do_read(8'd4, 0);
        sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'h00); sb.push_back(8'h00);
        repeat (4) xfer(8'h00);
        frame_end();
        check("short_read_pops", pop_cnt - p0, 32'd2);

        fifo_fill(8'hC0, 8);
        p0 = pop_cnt;
        do_read(8'd8, 0);
        sb.push_back(8'hC0); sb.push_back(8'hC1);
        repeat (2) xfer(8'h00);
        frame_end();
        repeat (6) @(negedge clk);
        check("abort_pops", pop_cnt - p0, 32'd3);
        frame_begin();
        xfer(8'h7F);
        sb.push_back(8'hEE);
        xfer(8'h00);
        frame_end();

        f0 = flush_cnt;
        one_cmd(8'h05);
        check("flush_pulse", flush_cnt - f0, 32'd1);
        check("flush_empty", {31'h0, fifo_empty}, 32'h1);
        check("flush_keeps_cap", {31'h0, capture_en}, 32'h1);

        @(negedge clk) force_full = 1'b1;
        @(negedge clk) force_full = 1'b0;
        do_status(8'hC8, 16'd5);
        f0 = flush_cnt;
        one_cmd(8'h05);
        check("flush2_pulse", flush_cnt - f0, 32'd1);
        do_status(8'h88, 16'd5);
        @(negedge clk) force_full = 1'b1;
        @(negedge clk) force_full = 1'b0;
        one_cmd(8'h01);
        do_status(8'h88, 16'd5);

        one_cmd(8'h01);
        repeat (130) @(negedge clk);
`ifdef CAPTURE_TIMEOUT_EN
        check("timeout_cap", {31'h0, capture_en}, 32'h0);
        do_status(8'h28, 16'd5);
`else
        check("no_timeout_cap", {31'h0, capture_en}, 32'h1);
        do_status(8'h88, 16'd5);
`endif

        one_cmd(8'h01);
        fifo_fill(8'hD0, 4);
        do_read(8'd4, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_tx", {24'h0, spi_tx_data}, 32'h00);
        check("arst_cap", {31'h0, capture_en}, 32'h0);
        check("arst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
